// File: rtl/g_func_sequencer.sv
// Arbitrates two requesters onto a byte-serial G datapath; result valid G_LAT+5 cycles after handshake.
// One word in flight; requesters stall outside IDLE and the result holds in DONE until r_ready.
module g_func_sequencer #(
   parameter int G_LAT = 5
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        a_valid,
   output logic        a_ready,
   input  logic [31:0] a_data,
   input  logic        b_valid,
   output logic        b_ready,
   input  logic [31:0] b_data,
   output logic [7:0]  g_inp,
   output logic        g_enable,
   input  logic [7:0]  g_outp,
   output logic        r_valid,
   input  logic        r_ready,
   output logic [31:0] r_data,
   output logic        r_id,
   output logic        busy
);

   // Four bits cover G_LAT up to 12; larger latencies need one more bit to reach G_LAT+3.
   localparam int CNT_W = (G_LAT + 3 > 15) ? 5 : 4;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(G_LAT + 3);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              last_grant_q, last_grant_d;
   logic [31:0]       word_q, word_d;
   logic              id_q, id_d;
   logic [31:0]       r_data_q, r_data_d;
   logic              grant_a;
   logic              grant_b;

   // last_grant: 0 = A, 1 = B; the requester not served last wins a tie.
   assign grant_a = a_valid && (!b_valid || last_grant_q);
   assign grant_b = b_valid && (!a_valid || !last_grant_q);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         last_grant_q <= 1'b1;
         word_q       <= '0;
         id_q         <= 1'b0;
         r_data_q     <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         last_grant_q <= last_grant_d;
         word_q       <= word_d;
         id_q         <= id_d;
         r_data_q     <= r_data_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      last_grant_d = last_grant_q;
      word_d       = word_q;
      id_d         = id_q;
      r_data_d     = r_data_q;
      a_ready      = 1'b0;
      b_ready      = 1'b0;
      g_inp        = 8'h00;
      g_enable     = 1'b0;
      r_valid      = 1'b0;

      case (state_q)
         S_IDLE: begin
            a_ready = grant_a;
            b_ready = grant_b;
            if (grant_a) begin
               word_d       = a_data;
               id_d         = 1'b0;
               last_grant_d = 1'b0;
               cnt_d        = '0;
               state_d      = S_RUN;
            end else if (grant_b) begin
               word_d       = b_data;
               id_d         = 1'b1;
               last_grant_d = 1'b1;
               cnt_d        = '0;
               state_d      = S_RUN;
            end
         end

         S_RUN: begin
            g_enable = 1'b1;
            for (int k = 0; k < 4; k++) begin
               if (cnt_q == CNT_W'(k)) begin
                  g_inp = word_q[8*k +: 8];
               end
               if (cnt_q == CNT_W'(G_LAT + k)) begin
                  r_data_d[8*k +: 8] = g_outp;
               end
            end
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         S_DONE: begin
            r_valid = 1'b1;
            if (r_ready) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy   = (state_q != S_IDLE);
   assign r_data = r_data_q;
   assign r_id   = id_q;

endmodule

// File: tb/tb_g_func_sequencer.sv
// Directed bench for g_func_sequencer with a G stub: g_outp = g_inp delayed G_LAT cycles, xor 8'h5A.
module tb_g_func_sequencer;
   localparam int G_LAT = 5;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        a_valid = 1'b0;
   logic        a_ready;
   logic [31:0] a_data = '0;
   logic        b_valid = 1'b0;
   logic        b_ready;
   logic [31:0] b_data = '0;
   logic [7:0]  g_inp;
   logic        g_enable;
   logic [7:0]  g_outp;
   logic        r_valid;
   logic        r_ready = 1'b0;
   logic [31:0] r_data;
   logic        r_id;
   logic        busy;

   int checks = 0;
   int failures = 0;

   logic [7:0] gpipe [G_LAT];

   g_func_sequencer #(.G_LAT(G_LAT)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .a_valid  (a_valid),
      .a_ready  (a_ready),
      .a_data   (a_data),
      .b_valid  (b_valid),
      .b_ready  (b_ready),
      .b_data   (b_data),
      .g_inp    (g_inp),
      .g_enable (g_enable),
      .g_outp   (g_outp),
      .r_valid  (r_valid),
      .r_ready  (r_ready),
      .r_data   (r_data),
      .r_id     (r_id),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < G_LAT; i++) gpipe[i] <= 8'h00;
      end else begin
         gpipe[0] <= g_inp;
         for (int i = 1; i < G_LAT; i++) gpipe[i] <= gpipe[i-1];
      end
   end
   assign g_outp = gpipe[G_LAT-1] ^ 8'h5A;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Ticks until r_valid is seen, giving up after 40 cycles.
   task automatic wait_rvalid(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!r_valid && n < 40);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_r_valid"},  r_valid,  0);
      chk({tag, "_r_data"},   r_data,   0);
      chk({tag, "_r_id"},     r_id,     0);
      chk({tag, "_g_inp"},    g_inp,    0);
      chk({tag, "_g_enable"}, g_enable, 0);
      chk({tag, "_busy"},     busy,     0);
      chk({tag, "_a_ready"},  a_ready,  0);
      chk({tag, "_b_ready"},  b_ready,  0);
   endtask

   initial begin
      int n;
      int seen;
      logic [31:0] bv [3];
      logic [31:0] bexp [3];
      bv[0] = 32'h01234567; bexp[0] = 32'h5B791F3D;
      bv[1] = 32'hDEADBEEF; bexp[1] = 32'h84F7E4B5;
      bv[2] = 32'h00FF00FF; bexp[2] = 32'h5AA55AA5;

      // Reset state
      tick();
      tick();
      chk_all_zero("reset");
      reset_n = 1'b1;
      tick();
      chk("idle_busy", busy, 0);

      // Single A with backpressure on the result
      a_data  = 32'h03020100;
      a_valid = 1'b1;
      #1;
      chk("a_ready_idle", a_ready, 1);
      chk("b_ready_idle", b_ready, 0);
      tick();
      a_valid = 1'b0;
      b_valid = 1'b1;
      #1;
      chk("run_b_ready", b_ready, 0);
      chk("run_busy", busy, 1);
      chk("run_g_enable", g_enable, 1);
      chk("feed_byte0", g_inp, 8'h00);
      tick();
      chk("feed_byte1", g_inp, 8'h01);
      tick();
      chk("feed_byte2", g_inp, 8'h02);
      tick();
      chk("feed_byte3", g_inp, 8'h03);
      for (int c = 5; c <= 9; c++) begin
         tick();
         chk("run_tail_g_enable", g_enable, 1);
         chk("run_tail_g_inp", g_inp, 8'h00);
         chk("run_tail_r_valid", r_valid, 0);
      end
      tick();
      a_valid = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("bp_r_valid", r_valid, 1);
         chk("bp_r_data", r_data, 32'h59585B5A);
         chk("bp_r_id", r_id, 0);
         chk("bp_a_ready", a_ready, 0);
         chk("bp_b_ready", b_ready, 0);
         chk("bp_busy", busy, 1);
         chk("bp_g_enable", g_enable, 0);
         tick();
      end
      r_ready = 1'b1;
      a_valid = 1'b0;
      b_valid = 1'b0;
      #1;
      chk("bp_accept_r_valid", r_valid, 1);
      tick();
      chk("bp_after_r_valid", r_valid, 0);
      chk("bp_after_busy", busy, 0);

      // Contention from reset: A, B, A
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      a_data  = 32'h11223344;
      b_data  = 32'hA0B0C0D0;
      a_valid = 1'b1;
      b_valid = 1'b1;
      #1;
      chk("cont_a_ready", a_ready, 1);
      chk("cont_b_ready", b_ready, 0);
      wait_rvalid(n);
      chk("cont1_latency", n, 10);
      chk("cont1_r_id", r_id, 0);
      chk("cont1_r_data", r_data, 32'h4B78691E);
      wait_rvalid(n);
      chk("cont2_period", n, 11);
      chk("cont2_r_id", r_id, 1);
      chk("cont2_r_data", r_data, 32'hFAEA9A8A);
      wait_rvalid(n);
      chk("cont3_period", n, 11);
      chk("cont3_r_id", r_id, 0);
      chk("cont3_r_data", r_data, 32'h4B78691E);

      // Back-to-back B only
      a_valid = 1'b0;
      for (int j = 0; j < 3; j++) begin
         b_data = bv[j];
         wait_rvalid(n);
         chk("b2b_period", n, 11);
         chk("b2b_r_id", r_id, 1);
         chk("b2b_r_data", r_data, bexp[j]);
      end
      b_valid = 1'b0;
      tick();
      chk("b2b_idle_busy", busy, 0);

      // Reset in the middle of RUN
      a_data  = 32'h12345678;
      a_valid = 1'b1;
      tick();
      a_valid = 1'b0;
      tick();
      tick();
      chk("mid_feed_byte2", g_inp, 8'h34);
      reset_n = 1'b0;
      #1;
      chk_all_zero("mid_reset");
      tick();
      reset_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (r_valid) seen++;
      end
      chk("post_reset_no_result", seen, 0);
      chk("post_reset_busy", busy, 0);
      a_data  = 32'hFFFFFFFF;
      a_valid = 1'b1;
      wait_rvalid(n);
      a_valid = 1'b0;
      chk("resubmit_latency", n, 10);
      chk("resubmit_r_data", r_data, 32'hA5A5A5A5);
      chk("resubmit_r_id", r_id, 0);
      tick();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
